// File: rtl/sumador_pkg.sv
`default_nettype none
// ============================================================================
// Module : sumador_pkg
// Shared op/state encodings and uio pin positions for the add/acc tile.
// Rev    : 1.0
// ============================================================================
package sumador_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_READY   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

  localparam int STB    = 0;
  localparam int START  = 1;
  localparam int OP_LSB = 2;
  localparam int BUSY   = 4;
  localparam int DONE   = 5;
  localparam int CARRY  = 6;
  localparam int OVF    = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/sumador_if.sv
`default_nettype none
// ============================================================================
// Module : sumador_if
// Tiny Tapeout user pin bundle (data, bidir status and enable).
// Rev    : 1.0
// ============================================================================
interface sumador_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface
`default_nettype wire

// File: rtl/sumador_alu.sv
`default_nettype none
// ============================================================================
// Module : sumador_alu
// Combinational WIDTH-bit add/subtract with carry and signed overflow.
// Rev    : 1.0
// ============================================================================
module sumador_alu
  import sumador_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    // Two's-complement subtract; the carry out is the no-borrow flag.
    diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    r     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD, OP_ACC: begin
        r     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        r     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      default: begin
        r     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sumador_core.sv
`default_nettype none
// ============================================================================
// Module : sumador_core
// Byte-serial operand load, single-cycle compute and byte-serial readout.
// Rev    : 1.0
// ============================================================================
module sumador_core
  import sumador_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  sumador_if.slave bus
);

  localparam int            NB        = WIDTH / 8;
  localparam int            CW        = $clog2(2 * NB);
  localparam logic [CW-1:0] LAST_LOAD = CW'(2 * NB - 1);
  localparam logic [CW-1:0] LAST_OUT  = CW'(NB - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             stb_prev_q, stb_prev_d;
  op_e              op_q, op_d;

  logic             stb;
  logic             start;
  op_e              op_in;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic             alu_carry, alu_ovf;
  logic [7:0]       out_byte;
  logic [7:0]       status;
  logic             unused_uio;

  assign stb        = bus.uio_in[STB] & ~stb_prev_q;
  assign start      = bus.uio_in[START];
  assign op_in      = op_e'(bus.uio_in[OP_LSB +: 2]);
  assign unused_uio = &{1'b0, bus.uio_in[7:4]};

  // ACC adds operand A into the running accumulator; B is not used.
  assign alu_a = (op_q == OP_ACC) ? acc_q : a_q;
  assign alu_b = (op_q == OP_ACC) ? a_q   : b_q;

  sumador_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .op    (op_q),
    .r     (alu_r),
    .carry (alu_carry),
    .ovf   (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      stb_prev_q <= 1'b0;
      op_q       <= OP_ADD;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      stb_prev_q <= stb_prev_d;
      op_q       <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    stb_prev_d = stb_prev_q;
    op_d       = op_q;

    if (bus.ena) begin
      stb_prev_d = bus.uio_in[STB];
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (stb) begin
            for (int k = 0; k < NB; k++) begin
              if (cnt_q == CW'(k))      a_d[8*k +: 8] = bus.ui_in;
              if (cnt_q == CW'(NB + k)) b_d[8*k +: 8] = bus.ui_in;
            end
            if (cnt_q == LAST_LOAD) begin
              state_d = ST_READY;
              cnt_d   = '0;
            end else begin
              state_d = ST_LOAD;
              cnt_d   = cnt_q + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (start) begin
            op_d    = op_in;
            state_d = ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          result_d = alu_r;
          carry_d  = alu_carry;
          ovf_d    = alu_ovf;
          if ((op_q == OP_ACC) || (op_q == OP_CLR)) acc_d = alu_r;
          cnt_d    = '0;
          state_d  = ST_OUT;
        end
        ST_OUT: begin
          if (stb) begin
            if (cnt_q == LAST_OUT) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    out_byte = '0;
    for (int k = 0; k < NB; k++) begin
      if (cnt_q == CW'(k)) out_byte = result_q[8*k +: 8];
    end
    status        = '0;
    status[BUSY]  = (state_q == ST_COMPUTE);
    status[DONE]  = (state_q == ST_OUT);
    status[CARRY] = carry_q;
    status[OVF]   = ovf_q;
  end

  assign bus.uo_out  = (state_q == ST_OUT) ? out_byte : 8'h00;
  assign bus.uio_out = status;
  assign bus.uio_oe  = UIO_OE_MASK;

endmodule
`default_nettype wire

// File: rtl/tt_um_sumador_acc.sv
`default_nettype none
// ============================================================================
// Module : tt_um_sumador_acc
// Tiny Tapeout top: WIDTH-bit add/sub/accumulate unit on the standard pins.
// Rev    : 1.0
// ============================================================================
module tt_um_sumador_acc #(
  parameter int WIDTH = 16
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  sumador_if u_bus ();

  assign u_bus.ena    = ena;
  assign u_bus.ui_in  = ui_in;
  assign u_bus.uio_in = uio_in;
  assign uo_out       = u_bus.uo_out;
  assign uio_out      = u_bus.uio_out;
  assign uio_oe       = u_bus.uio_oe;

  sumador_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_bus)
  );

endmodule
`default_nettype wire

// File: tb/tb_tt_um_sumador_acc.sv
`default_nettype none
// ============================================================================
// Module : tb_tt_um_sumador_acc
// Scoreboard bench for the add/acc tile at WIDTH 8, 16 and 32.
// Rev    : 1.0
// ============================================================================
module tb_tt_um_sumador_acc;
  import sumador_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  exp_bytes[$];
  logic [1:0]  exp_flags[$];
  logic [63:0] acc16;

  sumador_if bus8 ();
  sumador_if bus16 ();
  sumador_if bus32 ();

  tt_um_sumador_acc #(.WIDTH(8)) dut8 (
    .ui_in(bus8.ui_in), .uo_out(bus8.uo_out), .uio_in(bus8.uio_in),
    .uio_out(bus8.uio_out), .uio_oe(bus8.uio_oe), .ena(bus8.ena),
    .clk(clk), .rst_n(rst_n));

  tt_um_sumador_acc #(.WIDTH(16)) dut16 (
    .ui_in(bus16.ui_in), .uo_out(bus16.uo_out), .uio_in(bus16.uio_in),
    .uio_out(bus16.uio_out), .uio_oe(bus16.uio_oe), .ena(bus16.ena),
    .clk(clk), .rst_n(rst_n));

  tt_um_sumador_acc #(.WIDTH(32)) dut32 (
    .ui_in(bus32.ui_in), .uo_out(bus32.uo_out), .uio_in(bus32.uio_in),
    .uio_out(bus32.uio_out), .uio_oe(bus32.uio_oe), .ena(bus32.ena),
    .clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic [7:0] ui, input logic [7:0] uio);
    case (w)
      8:       begin bus8.ui_in  = ui; bus8.uio_in  = uio; end
      32:      begin bus32.ui_in = ui; bus32.uio_in = uio; end
      default: begin bus16.ui_in = ui; bus16.uio_in = uio; end
    endcase
  endtask

  task automatic set_ena(input int w, input logic e);
    case (w)
      8:       bus8.ena  = e;
      32:      bus32.ena = e;
      default: bus16.ena = e;
    endcase
  endtask

  function automatic logic [7:0] uo(input int w);
    case (w)
      8:       return bus8.uo_out;
      32:      return bus32.uo_out;
      default: return bus16.uo_out;
    endcase
  endfunction

  function automatic logic [7:0] uio(input int w);
    case (w)
      8:       return bus8.uio_out;
      32:      return bus32.uio_out;
      default: return bus16.uio_out;
    endcase
  endfunction

  function automatic logic [7:0] oe(input int w);
    case (w)
      8:       return bus8.uio_oe;
      32:      return bus32.uio_oe;
      default: return bus16.uio_oe;
    endcase
  endfunction

  task automatic strobe_byte(input int w, input logic [7:0] b);
    drive(w, b, 8'h01);
    tick();
    drive(w, b, 8'h00);
    tick();
  endtask

  task automatic load(input int w, input logic [63:0] a, input logic [63:0] b);
    int nb;
    nb = w / 8;
    for (int k = 0; k < 2 * nb; k++)
      strobe_byte(w, (k < nb) ? a[8*k +: 8] : b[8*(k-nb) +: 8]);
  endtask

  // Reference arithmetic on w-bit unsigned values; flags returned as {ovf, carry}.
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] op, inout logic [63:0] acc,
                       output logic [63:0] r, output logic [1:0] fl);
    logic [64:0] full;
    logic [63:0] mask;
    int          m;
    logic        c, v;
    m    = w - 1;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    full = '0;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin
        full = 65'(a) + 65'(b);
        r = full[63:0] & mask;
        c = full[w];
        v = (a[m] == b[m]) && (r[m] != a[m]);
      end
      2'b01: begin
        r = (a - b) & mask;
        c = (a >= b);
        v = (a[m] != b[m]) && (r[m] != a[m]);
      end
      2'b10: begin
        full = 65'(acc) + 65'(a);
        r = full[63:0] & mask;
        c = full[w];
        v = (acc[m] == a[m]) && (r[m] != acc[m]);
        acc = r;
      end
      default: acc = '0;
    endcase
    fl = {v, c};
  endtask

  task automatic exec_and_read(input int w, input logic [63:0] a, input logic [63:0] b,
                               input logic [1:0] op, input string name,
                               input bit start_stb, input bit freeze);
    logic [63:0] r;
    logic [1:0]  fl, want_fl;
    logic [7:0]  got, want;
    int          nb;
    nb = w / 8;
    model(w, a, b, op, acc16, r, fl);
    for (int k = 0; k < nb; k++) exp_bytes.push_back(r[8*k +: 8]);
    exp_flags.push_back(fl);

    drive(w, start_stb ? 8'hAA : 8'h00, {4'b0000, op, 1'b1, start_stb});
    tick();
    got = uio(w);
    checks++;
    if (got[5:4] !== 2'b01) begin
      errors++;
      $display("FAIL %s busy: uio_out[5:4]=%b expected 01", name, got[5:4]);
    end

    drive(w, 8'h00, 8'h00);
    tick();
    got = uio(w);
    want_fl = exp_flags.pop_front();
    checks++;
    if (got[5:4] !== 2'b10) begin
      errors++;
      $display("FAIL %s done: uio_out[5:4]=%b expected 10", name, got[5:4]);
    end
    checks++;
    if (got[7:6] !== want_fl) begin
      errors++;
      $display("FAIL %s flags: ovf,carry=%b expected %b", name, got[7:6], want_fl);
    end

    for (int k = 0; k < nb; k++) begin
      want = exp_bytes.pop_front();
      if (freeze && k == 1) begin
        set_ena(w, 1'b0);
        for (int j = 0; j < 5; j++) begin
          drive(w, 8'h00, (j % 2 == 0) ? 8'h01 : 8'h00);
          tick();
          checks++;
          if (uo(w) !== want) begin
            errors++;
            $display("FAIL %s freeze%0d: uo_out=%h expected %h", name, j, uo(w), want);
          end
        end
        drive(w, 8'h00, 8'h00);
        set_ena(w, 1'b1);
      end
      checks++;
      if (uo(w) !== want) begin
        errors++;
        $display("FAIL %s byte%0d: uo_out=%h expected %h", name, k, uo(w), want);
      end
      strobe_byte(w, 8'h00);
    end

    got = uio(w);
    checks++;
    if (uo(w) !== 8'h00 || got[5:4] !== 2'b00 || got[7:6] !== want_fl) begin
      errors++;
      $display("FAIL %s end: uo_out=%h uio_out=%h expected 00 and %h",
               name, uo(w), got, {want_fl, 6'b0});
    end
  endtask

  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input string name);
    load(w, a, b);
    exec_and_read(w, a, b, op, name, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    foreach (exp_bytes[i]) exp_bytes.delete();
    for (int i = 0; i < 3; i++) begin
      int w;
      w = (i == 0) ? 8 : ((i == 1) ? 16 : 32);
      set_ena(w, 1'b1);
      drive(w, 8'h00, 8'h00);
    end
    acc16 = '0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      int w;
      w = (i == 0) ? 8 : ((i == 1) ? 16 : 32);
      checks++;
      if (uo(w) !== 8'h00 || uio(w) !== 8'h00 || oe(w) !== 8'hF0) begin
        errors++;
        $display("FAIL reset w%0d: uo=%h uio=%h oe=%h expected 00 00 f0",
                 w, uo(w), uio(w), oe(w));
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    run_op(16, 64'h1234, 64'h0FF0, OP_ADD, "add_basic");
    run_op(16, 64'hFFFF, 64'h0001, OP_ADD, "add_carry");
    run_op(16, 64'h7FFF, 64'h0001, OP_ADD, "add_ovf");
  endtask

  task automatic test_sub();
    run_op(16, 64'h0005, 64'h0007, OP_SUB, "sub_borrow");
    run_op(16, 64'h8000, 64'h0001, OP_SUB, "sub_ovf");
  endtask

  task automatic test_accumulate();
    run_op(16, 64'h0000, 64'h0000, OP_CLR, "clr1");
    run_op(16, 64'h0100, 64'h5555, OP_ACC, "acc1");
    run_op(16, 64'h0100, 64'hAAAA, OP_ACC, "acc2");
    run_op(16, 64'hFF00, 64'h0000, OP_ACC, "acc_carry");
    run_op(16, 64'h1234, 64'h4321, OP_CLR, "clr2");
  endtask

  task automatic test_protocol();
    logic [7:0] got;
    drive(16, 8'h00, 8'h02);
    tick();
    got = uio(16);
    checks++;
    if (got[4] !== 1'b0) begin
      errors++;
      $display("FAIL idle_start: busy=%b expected 0", got[4]);
    end
    tick();
    got = uio(16);
    checks++;
    if (got[4] !== 1'b0) begin
      errors++;
      $display("FAIL idle_start2: busy=%b expected 0", got[4]);
    end
    drive(16, 8'h00, 8'h00);
    tick();

    // Held strobe: four high cycles must load only the first byte.
    drive(16, 8'h01, 8'h01);
    repeat (4) tick();
    drive(16, 8'h01, 8'h00);
    tick();
    strobe_byte(16, 8'h00);
    strobe_byte(16, 8'h02);
    strobe_byte(16, 8'h00);
    exec_and_read(16, 64'h0001, 64'h0002, OP_ADD, "held_stb", 1'b0, 1'b0);

    load(16, 64'h1111, 64'h2222);
    strobe_byte(16, 8'h55);
    exec_and_read(16, 64'h1111, 64'h2222, OP_ADD, "start_stb", 1'b1, 1'b0);

    load(16, 64'hBEEF, 64'h1357);
    exec_and_read(16, 64'hBEEF, 64'h1357, OP_SUB, "ena_freeze", 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    run_op(16, 64'hFFFF, 64'h0001, OP_ADD, "pre_reset");
    strobe_byte(16, 8'h11);
    strobe_byte(16, 8'h22);
    strobe_byte(16, 8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    got = uio(16);
    checks++;
    if (uo(16) !== 8'h00 || got !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: uo=%h uio=%h expected 00 00", uo(16), got);
    end
    #1;
    rst_n = 1'b1;
    acc16 = '0;
    tick();
    run_op(16, 64'h0001, 64'h0001, OP_ADD, "post_reset");
  endtask

  task automatic test_widths();
    run_op(8, 64'h34, 64'h12, OP_ADD, "w8_add");
    run_op(8, 64'h7F, 64'h01, OP_ADD, "w8_ovf");
    run_op(32, 64'h0FF0_1234, 64'h1234_5678, OP_ADD, "w32_add");
    run_op(32, 64'hFFFF_FFFF, 64'h0000_0001, OP_ADD, "w32_carry");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_accumulate();
    test_protocol();
    test_reset_mid();
    test_widths();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
